fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 Parameter: MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered memory requests.
REQ-004 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: imem_req_valid  out  1  fetch request valid.
REQ-007 Port: imem_req_ready  in  1  memory accepts request this cycle.
REQ-008 Port: imem_addr  out  32  word-aligned fetch address.
REQ-009 Port: imem_resp_valid  in  1  instruction word returned (in request order).
REQ-010 Port: imem_resp_data  in  32  returned instruction word.
REQ-011 Port: redirect_valid  in  1  branch/jump taken; discard all younger work.
REQ-012 Port: redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0).
REQ-013 Port: instruction  out  32  head-of-buffer instruction to control decoder.
REQ-014 Port: inst_pc  out  32  PC of head instruction (for op_A_sel PC / PC+4 paths).
REQ-015 Port: inst_valid  out  1  buffer head holds a valid instruction.
REQ-016 Port: inst_ready  in  1  downstream consumes head this cycle.

Function
REQ-017 Request accepted when imem_req_valid && imem_req_ready; fetch PC then advances by 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-018 imem_req_valid SHALL assert only in RUN and when outstanding + buffer occupancy < BUF_DEPTH and outstanding < MAX_OUTSTANDING (no response may ever find buffer full).
REQ-019 imem_addr SHALL equal the fetch PC whenever imem_req_valid is high; stable while valid && !ready.
REQ-020 Each response in RUN SHALL be written to the buffer tail with its PC (PC tag FIFO in parallel); outstanding decrements on every imem_resp_valid.
REQ-021 Same-cycle accept and response: outstanding unchanged.
REQ-022 Pop when inst_valid && inst_ready; simultaneous push and pop allowed at any occupancy, including full.
REQ-023 Buffer empty -> inst_valid=0; instruction and inst_pc are don't-care but SHALL not be X after reset (driven from storage reset to 0).
REQ-024 Latency: response in cycle N appears on instruction/inst_valid in cycle N+1 (registered buffer, no bypass).
REQ-025 States: RUN, DRAIN.
REQ-026 RUN + redirect_valid: fetch PC <= {redirect_pc[31:2],2'b00}; buffer cleared; no request issued that cycle; next state DRAIN if outstanding (after this cycle's response) >0, else RUN.
REQ-027 DRAIN: imem_req_valid=0; all responses discarded (not written); -> RUN when outstanding reaches 0.
REQ-028 redirect_valid in DRAIN: fetch PC updated to new target; remains DRAIN.
REQ-029 Redirect wins over simultaneous pop, push, or response in the same cycle; pop that cycle has no effect on cleared buffer.
REQ-030 inst_valid SHALL be 0 in the cycle after any redirect.
REQ-031 Response arriving with outstanding==0 is a protocol violation; ignored, counter saturates at 0.

Reset
REQ-032 While reset==0 at a rising edge: fetch PC=RESET_PC, state=RUN, outstanding=0, buffer empty, pointers 0, storage 0.
REQ-033 During and in the cycle after reset: imem_req_valid=0, inst_valid=0, instruction=0, inst_pc=0.
REQ-034 Reset mid-operation SHALL abandon in-flight requests; responses arriving after reset deasserts and before any new accept are ignored per REQ-031.
REQ-035 First request issued the second cycle after reset deassertion, imem_addr=RESET_PC.

Verification
REQ-036 Streaming: ready=1, 1-cycle memory, inst_ready=1 -> addresses 0,4,8,... one per cycle; inst_pc follows with 2-cycle lag; no bubbles after fill.
REQ-037 Backpressure: inst_ready=0 -> exactly BUF_DEPTH (2) instructions buffered, imem_req_valid drops; release -> order and PCs 0,4 preserved, no loss/duplicate.
REQ-038 Redirect with 2 outstanding: redirect_pc=32'h0000_0103 -> DRAIN, both responses dropped, next imem_addr=32'h0000_0100, first inst_pc=32'h0000_0100.
REQ-039 Redirect coincident with pop and response at full buffer -> buffer empty next cycle, inst_valid=0, no stale instruction emitted.
REQ-040 Wrap: RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 Reset asserted with 2 outstanding and full buffer -> next cycle all outputs 0, late responses ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory and
// buffers returned words with their PCs for the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    logic            started;
    logic [31:0]     fetch_pc;
    logic [31:0]     resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   out_next;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [31:0]     inst_mem [BUF_DEPTH];
    logic [31:0]     pc_mem   [BUF_DEPTH];

    logic            pop;
    logic            rsp;
    logic            acc;
    logic            push;
    logic [31:0]     occ;
    logic [31:0]     target;
    logic            unused_bits;

    assign target      = {redirect_pc[31:2], 2'b00};
    assign unused_bits = ^redirect_pc[1:0];

    assign inst_valid  = (count != '0);
    assign instruction = inst_mem[rd_ptr];
    assign inst_pc     = pc_mem[rd_ptr];
    assign imem_addr   = fetch_pc;

    // Request gating: every accepted request must have a guaranteed buffer
    // slot, counting the entry that leaves this cycle through a pop.
    always_comb begin
        pop  = inst_valid && inst_ready;
        rsp  = imem_resp_valid && (outstanding != '0);
        occ  = 32'(outstanding) + 32'(count) - 32'(pop);
        imem_req_valid = started && (state == RUN) && !redirect_valid
                         && (occ < 32'(BUF_DEPTH))
                         && (32'(outstanding) < 32'(MAX_OUTSTANDING));
        acc  = imem_req_valid && imem_req_ready;
        push = (state == RUN) && rsp && !redirect_valid;
        out_next = outstanding + OW'(acc) - OW'(rsp);
    end

    // Fetch PC, response PC tag, outstanding count and RUN/DRAIN control.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= RUN;
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= out_next;
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                if (state == DRAIN || out_next != '0)
                    state <= DRAIN;
                else
                    state <= RUN;
            end else begin
                if (acc)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push)
                    resp_pc <= resp_pc + 32'd4;
                if (state == DRAIN && out_next == '0)
                    state <= RUN;
            end
        end
    end

    // Instruction buffer with parallel PC tags; redirect flushes it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                inst_mem[wr_ptr] <= imem_resp_data;
                pc_mem[wr_ptr]   <= resp_pc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: streaming, backpressure, redirects,
// PC wrap and mid-operation reset.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    logic        w_req_valid;
    logic [31:0] w_addr;
    logic [31:0] w_instruction;
    logic [31:0] w_inst_pc;
    logic        w_inst_valid;

    logic        mem_on;
    int          total;
    int          bad;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (w_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (w_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instruction    (w_instruction),
        .inst_pc        (w_inst_pc),
        .inst_valid     (w_inst_valid),
        .inst_ready     (inst_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; a 1-cycle memory answers last cycle's accept when enabled.
    task automatic cyc();
        logic        a;
        logic [31:0] ad;
        #1;
        a  = imem_req_valid && imem_req_ready;
        ad = imem_addr;
        @(posedge clock);
        #1;
        imem_resp_valid = mem_on && a;
        imem_resp_data  = ad ^ 32'hA5A5_0000;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;
        mem_on = 1'b1;

        // reset state
        cyc();
        cyc();
        chk("rst_req", imem_req_valid, 0);
        chk("rst_ivalid", inst_valid, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_ipc", inst_pc, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_req", imem_req_valid, 0);
        cyc();

        // streaming and wrap
        chk("first_req", imem_req_valid, 1);
        chk("first_addr", imem_addr, 32'h0);
        chk("wrap_a0", w_addr, 32'hFFFF_FFF8);
        cyc();
        chk("s_addr4", imem_addr, 32'h4);
        chk("s_ivalid_c3", inst_valid, 0);
        chk("wrap_a1", w_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_a2", w_addr, 32'h0);
        chk("wrap_req", w_req_valid, 1);
        chk("wrap_ipc", w_inst_pc, 32'hFFFF_FFF8);
        chk("wrap_instr", w_instruction, 32'hA5A5_0000);
        chk("wrap_ivalid", w_inst_valid, 1);
        for (int k = 0; k < 4; k++) begin
            chk("s_req", imem_req_valid, 1);
            chk("s_addr", imem_addr, 32'(4 * k + 8));
            chk("s_ivalid", inst_valid, 1);
            chk("s_ipc", inst_pc, 32'(4 * k));
            chk("s_instr", instruction, 32'(4 * k) ^ 32'hA5A5_0000);
            cyc();
        end

        // backpressure
        inst_ready = 1'b0;
        do_reset();
        chk("bp_addr0", imem_addr, 32'h0);
        chk("bp_req0", imem_req_valid, 1);
        cyc();
        chk("bp_addr1", imem_addr, 32'h4);
        cyc();
        chk("bp_req_drop", imem_req_valid, 0);
        chk("bp_ivalid", inst_valid, 1);
        chk("bp_ipc", inst_pc, 32'h0);
        cyc();
        chk("bp_req_hold", imem_req_valid, 0);
        cyc();
        chk("bp_req_hold2", imem_req_valid, 0);
        chk("bp_ipc_hold", inst_pc, 32'h0);
        inst_ready = 1'b1;
        #1;
        chk("bp_rel_instr", instruction, 32'hA5A5_0000);
        chk("bp_rel_req", imem_req_valid, 1);
        chk("bp_rel_addr", imem_addr, 32'h8);
        cyc();
        chk("bp_rel_ipc1", inst_pc, 32'h4);
        chk("bp_rel_instr1", instruction, 32'hA5A5_0004);
        cyc();
        chk("bp_rel_ipc2", inst_pc, 32'h8);

        // redirect at full buffer with pop and response
        inst_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        cyc();
        chk("full_ivalid", inst_valid, 1);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0302;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hBAD0_0000;
        #1;
        chk("rf_no_req", imem_req_valid, 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("rf_empty", inst_valid, 0);
        chk("rf_req", imem_req_valid, 1);
        chk("rf_addr", imem_addr, 32'h300);
        cyc();
        chk("rf_ivalid_c7", inst_valid, 0);
        cyc();
        chk("rf_ivalid", inst_valid, 1);
        chk("rf_ipc", inst_pc, 32'h300);
        chk("rf_instr", instruction, 32'hA5A5_0300);

        // redirect with two outstanding
        mem_on = 1'b0;
        do_reset();
        cyc();
        cyc();
        chk("dr_req_max", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("dr_req", imem_req_valid, 0);
        chk("dr_ivalid", inst_valid, 0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_0000;
        cyc();
        chk("dr_ivalid1", inst_valid, 0);
        chk("dr_req1", imem_req_valid, 0);
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_0004;
        cyc();
        chk("dr_req_run", imem_req_valid, 1);
        chk("dr_addr", imem_addr, 32'h100);
        chk("dr_ivalid2", inst_valid, 0);
        mem_on = 1'b1;
        cyc();
        chk("dr_ivalid3", inst_valid, 0);
        cyc();
        chk("dr_ivalid4", inst_valid, 1);
        chk("dr_ipc", inst_pc, 32'h100);
        chk("dr_instr", instruction, 32'hA5A5_0100);

        // reset with two outstanding
        mem_on = 1'b0;
        do_reset();
        cyc();
        cyc();
        chk("mr_req_max", imem_req_valid, 0);
        reset = 1'b0;
        cyc();
        chk("mr_req", imem_req_valid, 0);
        chk("mr_ivalid", inst_valid, 0);
        chk("mr_instr", instruction, 0);
        chk("mr_ipc", inst_pc, 0);
        reset = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hBAD0_0004;
        cyc();
        chk("mr_restart_req", imem_req_valid, 1);
        chk("mr_restart_addr", imem_addr, 32'h0);
        chk("mr_wrap_addr", w_addr, 32'hFFFF_FFF8);
        chk("mr_late_ivalid", inst_valid, 0);
        cyc();
        chk("mr_late_ivalid2", inst_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
